pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 11 +
 rtl/pipe_hazard_ctrl_reg_dep_cmp.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and state type for the pipeline hazard controller.
// Imported by pipe_hazard_ctrl and reg_dep_cmp.
package pipe_hazard_ctrl_pkg;
    localparam int WORD_LEN       = 32;
    localparam int REG_AW_DEFAULT = 5;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hz_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_reg_dep_cmp.sv
// reg_dep_cmp: flags when a destination register feeds a used ID source.
// x0 never matches.
module reg_dep_cmp
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] i_rd,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic              i_rs1_used,
    input  logic              i_rs2_used,
    output logic              o_hit
);
    logic w_rd_nonzero;

    assign w_rd_nonzero = (i_rd != '0);
    assign o_hit = w_rd_nonzero &&
                   ((i_rs1_used && (i_rd == i_rs1)) ||
                    (i_rs2_used && (i_rd == i_rs2)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / branch-operand hazard controller for a 5-stage pipeline.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
//
// Control outputs are combinational from the current state and the hazard
// inputs; only the one-cycle HOLD of a double stall is registered.
// There is no valid/ready handshake: every output is meaningful every cycle.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_is_branch,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_mem_read,
    input  logic              ex_branch_taken,
    output logic              pc_stall,
    output logic              if2id_stall,
    output logic              if2id_stall_twice,
    output logic              if2id_flush,
    output logic              id2ex_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_events,
`endif
    output hz_state_t         dbg_state
);
    hz_state_t r_state;
    hz_state_t w_next_state;
    logic      w_ex_hit;
    logic      w_mem_hit;
    logic      w_dep_ex;
    logic      w_dep_mem;
    logic      w_double;
    logic      w_single;

    reg_dep_cmp #(.REG_AW(REG_AW)) u_dep_ex (
        .i_rd       (ex_rd),
        .i_rs1      (id_rs1),
        .i_rs2      (id_rs2),
        .i_rs1_used (id_rs1_used),
        .i_rs2_used (id_rs2_used),
        .o_hit      (w_ex_hit)
    );

    reg_dep_cmp #(.REG_AW(REG_AW)) u_dep_mem (
        .i_rd       (mem_rd),
        .i_rs1      (id_rs1),
        .i_rs2      (id_rs2),
        .i_rs1_used (id_rs1_used),
        .i_rs2_used (id_rs2_used),
        .o_hit      (w_mem_hit)
    );

    assign w_dep_ex  = ex_reg_write && w_ex_hit;
    assign w_dep_mem = mem_mem_read && w_mem_hit;

    // A branch in ID behind a load needs the loaded value from WB: two bubbles.
    assign w_double = id_is_branch && ex_mem_read && w_dep_ex;
    assign w_single = (ex_mem_read && w_dep_ex && !id_is_branch) ||
                      (id_is_branch && w_dep_ex && !ex_mem_read) ||
                      (id_is_branch && w_dep_mem);

    always_comb begin
        pc_stall          = 1'b0;
        if2id_stall       = 1'b0;
        if2id_stall_twice = 1'b0;
        if2id_flush       = 1'b0;
        id2ex_flush       = 1'b0;
        w_next_state      = IDLE;
        if (!nReset) begin
            w_next_state = IDLE;
        end else if (ex_branch_taken) begin
            if2id_flush = 1'b1;
            id2ex_flush = 1'b1;
        end else if (r_state == HOLD) begin
            pc_stall    = 1'b1;
            if2id_stall = 1'b1;
            id2ex_flush = 1'b1;
        end else if (w_double) begin
            pc_stall          = 1'b1;
            if2id_stall       = 1'b1;
            if2id_stall_twice = 1'b1;
            id2ex_flush       = 1'b1;
            w_next_state      = HOLD;
        end else if (w_single) begin
            pc_stall    = 1'b1;
            if2id_stall = 1'b1;
            id2ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign dbg_state = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] r_stall_cycles;
    logic [PERF_W-1:0] r_flush_events;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (pc_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (ex_branch_taken && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`else
    // PERF_W stays in the parameter list so both builds share one instantiation.
    if (PERF_W < 1) begin : g_perf_w_unused
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios plus
// randomized traffic, checked against a stall-budget reference model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int AW = 5;
  localparam int PW = 32;

  logic          clk;
  logic          nReset;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic          id_rs1_used, id_rs2_used, id_is_branch;
  logic          ex_reg_write, ex_mem_read, mem_mem_read, ex_branch_taken;
  logic          pc_stall, if2id_stall, if2id_stall_twice, if2id_flush, id2ex_flush;
  hz_state_t     dbg_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [PW-1:0] stall_cycles, flush_events;
`endif

  pipe_hazard_ctrl #(.REG_AW(AW), .PERF_W(PW)) dut (
    .clk               (clk),
    .nReset            (nReset),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_rs1_used       (id_rs1_used),
    .id_rs2_used       (id_rs2_used),
    .id_is_branch      (id_is_branch),
    .ex_rd             (ex_rd),
    .ex_reg_write      (ex_reg_write),
    .ex_mem_read       (ex_mem_read),
    .mem_rd            (mem_rd),
    .mem_mem_read      (mem_mem_read),
    .ex_branch_taken   (ex_branch_taken),
    .pc_stall          (pc_stall),
    .if2id_stall       (if2id_stall),
    .if2id_stall_twice (if2id_stall_twice),
    .if2id_flush       (if2id_flush),
    .id2ex_flush       (id2ex_flush),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles      (stall_cycles),
    .flush_events      (flush_events),
`endif
    .dbg_state         (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: {hold_state, pc_stall, if2id_stall, stall_twice, if2id_flush, id2ex_flush}
  logic [5:0] exp_q[$];
  string      tag_q[$];
  int         total = 0;
  int         bad = 0;

  // reference model: number of stall cycles still owed to an earlier hazard
  int          m_left = 0;
  int unsigned m_stall_cnt = 0;
  int unsigned m_flush_cnt = 0;

  function automatic bit src_hit(input logic [AW-1:0] rd);
    return (rd != 0) && ((id_rs1_used && rd == id_rs1) || (id_rs2_used && rd == id_rs2));
  endfunction

  // driver: apply one cycle of inputs just after the rising edge
  task automatic drive(input logic rst_n_v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic u1, input logic u2, input logic br,
                       input logic [AW-1:0] erd, input logic ew, input logic el,
                       input logic [AW-1:0] mrd, input logic ml, input logic tk, input string name);
    logic [5:0] e;
    bit dep_e, dep_m, hold;
    int need;
    @(posedge clk);
    #1;
    nReset = rst_n_v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
    id_is_branch = br; ex_rd = erd; ex_reg_write = ew; ex_mem_read = el;
    mem_rd = mrd; mem_mem_read = ml; ex_branch_taken = tk;
    e = '0;
    if (!rst_n_v) begin
      m_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      dep_e = ew && src_hit(erd);
      dep_m = ml && src_hit(mrd);
      hold  = (m_left > 0);
      e[5]  = hold;
      if (tk) begin
        e[1] = 1'b1; e[0] = 1'b1; m_left = 0;
        m_flush_cnt++;
      end else if (hold) begin
        e[4] = 1'b1; e[3] = 1'b1; e[0] = 1'b1; m_left--;
      end else begin
        need = 0;
        if (br && el && dep_e) need = 2;
        else if ((el && dep_e) || (br && dep_e) || (br && dep_m)) need = 1;
        if (need > 0) begin
          e[4] = 1'b1; e[3] = 1'b1; e[0] = 1'b1;
          e[2] = (need == 2);
          m_left = need - 1;
        end
      end
      if (e[4]) m_stall_cnt++;
    end
    exp_q.push_back(e);
    tag_q.push_back(name);
  endtask

  task automatic idle(input string name);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, name);
  endtask

  // monitor: outputs are valid every cycle, checked mid-cycle
  always @(negedge clk) begin
    logic [5:0] got, e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = tag_q.pop_front();
      got = {dbg_state == HOLD, pc_stall, if2id_stall, if2id_stall_twice, if2id_flush, id2ex_flush};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s: got st/pc/ifs/twice/iff/idf=%b required %b", nm, got, e);
      end
    end
  end

  initial begin
    logic [AW-1:0] r1, r2, erd, mrd;
    nReset = 1'b0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_is_branch = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_rd = 0; mem_mem_read = 0; ex_branch_taken = 0;

    // reset holds everything low even with a hazard present
    drive(1'b0, 5, 2, 1, 1, 1, 5, 1, 1, 5, 1, 0, "reset_hazard");
    drive(1'b0, 5, 2, 1, 1, 0, 5, 1, 1, 0, 0, 1, "reset_redirect");
    idle("reset_release");

`ifdef HAZARD_PERF_CNT_EN
    // one double stall, one single stall, one redirect
    drive(1'b1, 5, 2, 1, 1, 1, 5, 1, 1, 0, 0, 0, "perf_double");
    idle("perf_hold");
    drive(1'b1, 5, 1, 1, 1, 0, 5, 1, 1, 0, 0, 0, "perf_single");
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "perf_redirect");
    idle("perf_idle");
    @(negedge clk);
    total++;
    if (stall_cycles !== 3 || flush_events !== 1) begin
      bad++;
      $display("FAIL perf_counts: got stall=%0d flush=%0d required stall=3 flush=1",
               stall_cycles, flush_events);
    end
`endif

    // lw x5 in EX; add x6,x5,x1 in ID
    drive(1'b1, 5, 1, 1, 1, 0, 5, 1, 1, 0, 0, 0, "load_use");
    idle("load_use_after");
    // lw x5 in EX; beq x5,x2 in ID
    drive(1'b1, 5, 2, 1, 1, 1, 5, 1, 1, 0, 0, 0, "br_load_double");
    drive(1'b1, 5, 2, 1, 1, 1, 0, 0, 0, 5, 1, 0, "br_load_hold");
    idle("br_load_after");
    // lw x0; add x6,x0,x0
    drive(1'b1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, "x0_no_hazard");
    // branch on ALU result in EX, then branch on load in MEM
    drive(1'b1, 3, 4, 1, 1, 1, 4, 1, 0, 0, 0, 0, "br_alu_ex");
    drive(1'b1, 3, 4, 1, 1, 1, 0, 0, 0, 3, 1, 0, "br_load_mem");
    // unused source does not create a hazard
    drive(1'b1, 7, 5, 1, 0, 0, 5, 1, 1, 0, 0, 0, "rs2_unused");
    // redirect during HOLD aborts the second stall
    drive(1'b1, 5, 2, 1, 1, 1, 5, 1, 1, 0, 0, 0, "abort_double");
    drive(1'b1, 5, 2, 1, 1, 1, 5, 1, 1, 5, 1, 1, "abort_redirect");
    idle("abort_after");
    // reset asserted in HOLD: outputs drop at once, no residual stall
    drive(1'b1, 5, 2, 1, 1, 1, 5, 1, 1, 0, 0, 0, "rst_hold_double");
    drive(1'b0, 5, 2, 1, 1, 1, 5, 1, 1, 0, 0, 0, "rst_in_hold");
    idle("rst_hold_release");
    idle("rst_hold_after");

    // randomized traffic over a small register pool to provoke hits
    for (int i = 0; i < 400; i++) begin
      r1  = AW'($urandom_range(0, 3));
      r2  = AW'($urandom_range(0, 3));
      erd = AW'($urandom_range(0, 3));
      mrd = AW'($urandom_range(0, 3));
      drive(($urandom_range(0, 49) != 0), r1, r2, 1'($urandom), 1'($urandom), 1'($urandom),
            erd, 1'($urandom_range(0, 3) != 0), 1'($urandom), mrd, 1'($urandom),
            ($urandom_range(0, 7) == 0), "random");
    end

`ifdef HAZARD_PERF_CNT_EN
    idle("rand_perf_idle");
    @(negedge clk);
    total++;
    if (stall_cycles !== PW'(m_stall_cnt) || flush_events !== PW'(m_flush_cnt)) begin
      bad++;
      $display("FAIL rand_perf_counts: got stall=%0d flush=%0d required stall=%0d flush=%0d",
               stall_cycles, flush_events, m_stall_cnt, m_flush_cnt);
    end
`endif

    idle("drain");
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
